// File: rtl/td4_core_param.sv
// td4_core_param: single-cycle TD4-class accumulator core with
// parametrised data and program-counter widths. Registers A, B, the output
// latch, pc and carry all update on the same rising edge when en is high.
// The program ROM is outside the core. It sees pc_out and returns
// opcode/immediate combinationally within the same cycle.
module td4_core_param #(
    parameter int DATA_W = 4,
    parameter int PC_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] immediate,
    input  logic [DATA_W-1:0] in_port,
    output logic [PC_W-1:0]   pc_out,
    output logic [DATA_W-1:0] regA_o,
    output logic [DATA_W-1:0] regB_o,
    output logic [DATA_W-1:0] regOut,
    output logic              carry
);

    // Reject parameter combinations the instruction encoding cannot support.
    if (DATA_W < 2) begin : g_bad_data_w
        $error("td4_core_param: DATA_W must be at least 2");
    end
    if (PC_W < 1 || PC_W > DATA_W) begin : g_bad_pc_w
        $error("td4_core_param: PC_W must be in 1..DATA_W");
    end

    typedef enum logic [3:0] {
        OP_ADD_A_IM = 4'b0000,
        OP_MOV_A_B  = 4'b0001,
        OP_IN_A     = 4'b0010,
        OP_MOV_A_IM = 4'b0011,
        OP_MOV_B_A  = 4'b0100,
        OP_ADD_B_IM = 4'b0101,
        OP_IN_B     = 4'b0110,
        OP_MOV_B_IM = 4'b0111,
        OP_OUT_B    = 4'b1001,
        OP_OUT_IM   = 4'b1011,
        OP_JNC_IM   = 4'b1110,
        OP_JMP_IM   = 4'b1111
    } op_e;

    logic [DATA_W-1:0] reg_a, reg_b, reg_out;
    logic [PC_W-1:0]   pc;
    logic              carry_q;

    logic [DATA_W-1:0] a_nxt, b_nxt, out_nxt;
    logic [PC_W-1:0]   pc_nxt;
    logic              carry_nxt;

    // The extra top bit of each sum is the carry out of bit DATA_W-1.
    logic [DATA_W:0]   sum_a, sum_b;
    assign sum_a = {1'b0, reg_a} + {1'b0, immediate};
    assign sum_b = {1'b0, reg_b} + {1'b0, immediate};

    // Decode: compute the next architectural state for the current instruction.
    always_comb begin
        // NOTE: every output gets a default before the case statement. An opcode that leaves a signal unassigned then keeps its value without inferring a latch.
        a_nxt     = reg_a;
        b_nxt     = reg_b;
        out_nxt   = reg_out;
        pc_nxt    = pc + PC_W'(1);
        carry_nxt = 1'b0;
        case (opcode)
            OP_ADD_A_IM: begin
                a_nxt     = sum_a[DATA_W-1:0];
                carry_nxt = sum_a[DATA_W];
            end
            OP_MOV_A_B:  a_nxt = reg_b;
            OP_IN_A:     a_nxt = in_port;
            OP_MOV_A_IM: a_nxt = immediate;
            OP_MOV_B_A:  b_nxt = reg_a;
            OP_ADD_B_IM: begin
                b_nxt     = sum_b[DATA_W-1:0];
                carry_nxt = sum_b[DATA_W];
            end
            OP_IN_B:     b_nxt = in_port;
            OP_MOV_B_IM: b_nxt = immediate;
            OP_OUT_B:    out_nxt = reg_b;
            OP_OUT_IM:   out_nxt = immediate;
            // JNC tests the carry from the previous instruction. The default above then clears carry.
            OP_JNC_IM:   if (!carry_q) pc_nxt = immediate[PC_W-1:0];
            OP_JMP_IM:   pc_nxt = immediate[PC_W-1:0];
            default:     ; // NOP: only pc advances and carry clears
        endcase
    end

    // Architectural state: commit the decoded next state on an enabled edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_a   <= '0;
            reg_b   <= '0;
            reg_out <= '0;
            pc      <= '0;
            carry_q <= 1'b0;
        end else if (en) begin
            // NOTE: non-blocking assignments commit all registers together. MOV A,B and MOV B,A therefore see the values from before the edge.
            reg_a   <= a_nxt;
            reg_b   <= b_nxt;
            reg_out <= out_nxt;
            pc      <= pc_nxt;
            carry_q <= carry_nxt;
        end
    end

    assign pc_out = pc;
    assign regA_o = reg_a;
    assign regB_o = reg_b;
    assign regOut = reg_out;
    assign carry  = carry_q;

endmodule

// File: tb/tb_td4_core_param.sv
// tb_td4_core_param: randomized and directed stimulus on two core instances.
// One instance uses a 4-bit datapath and the other an 8-bit datapath, both with a
// 4-bit pc. A behavioural instruction-level model predicts the state of each core.
module tb_td4_core_param;

    localparam int OP_ADDA = 0, OP_MOVAB = 1, OP_INA = 2, OP_MOVAI = 3;
    localparam int OP_MOVBA = 4, OP_ADDB = 5, OP_INB = 6, OP_MOVBI = 7;
    localparam int OP_NOP = 8, OP_OUTB = 9, OP_OUTI = 11, OP_JNC = 14, OP_JMP = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       en4, en8;
    logic [3:0] op4, op8;
    logic [3:0] imm4, in4;
    logic [7:0] imm8, in8;
    logic [3:0] pc4, a4, b4, o4;
    logic       c4;
    logic [3:0] pc8;
    logic [7:0] a8, b8, o8;
    logic       c8;

    int vectors = 0;
    int miscompares = 0;
    bit run = 1'b0;

    // Model state: index 0 is the 4-bit core, index 1 is the 8-bit core.
    int m_a[2], m_b[2], m_o[2], m_pc[2], m_c[2];

    td4_core_param #(.DATA_W(4), .PC_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en4), .opcode(op4), .immediate(imm4),
        .in_port(in4), .pc_out(pc4), .regA_o(a4), .regB_o(b4), .regOut(o4),
        .carry(c4)
    );

    td4_core_param #(.DATA_W(8), .PC_W(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .en(en8), .opcode(op8), .immediate(imm8),
        .in_port(in8), .pc_out(pc8), .regA_o(a8), .regB_o(b8), .regOut(o8),
        .carry(c8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_a[d] = 0; m_b[d] = 0; m_o[d] = 0; m_pc[d] = 0; m_c[d] = 0;
        end
    endtask

    // Instruction-level semantics in plain integer arithmetic.
    task automatic model_step(input int d, input int op, input int imm, input int inp);
        int w, mask, im, ip, s, npc, nc;
        w    = (d == 0) ? 4 : 8;
        mask = (1 << w) - 1;
        im   = imm & mask;
        ip   = inp & mask;
        npc  = (m_pc[d] + 1) % 16;
        nc   = 0;
        case (op)
            OP_ADDA:  begin s = m_a[d] + im; m_a[d] = s & mask; nc = s >> w; end
            OP_MOVAB: m_a[d] = m_b[d];
            OP_INA:   m_a[d] = ip;
            OP_MOVAI: m_a[d] = im;
            OP_MOVBA: m_b[d] = m_a[d];
            OP_ADDB:  begin s = m_b[d] + im; m_b[d] = s & mask; nc = s >> w; end
            OP_INB:   m_b[d] = ip;
            OP_MOVBI: m_b[d] = im;
            OP_OUTB:  m_o[d] = m_b[d];
            OP_OUTI:  m_o[d] = im;
            OP_JNC:   if (m_c[d] == 0) npc = im % 16;
            OP_JMP:   npc = im % 16;
            default:  ;
        endcase
        m_pc[d] = npc;
        m_c[d]  = nc;
    endtask

    // Execute one edge. sel 0 enables the 4-bit core, sel 1 the 8-bit core, any other value neither.
    // A disabled core receives random opcodes and operands, which must not change its state.
    task automatic exec(input int sel, input int op, input int imm, input int inp);
        en4  = (sel == 0);
        en8  = (sel == 1);
        op4  = (sel == 0) ? 4'(op)  : 4'($urandom);
        imm4 = (sel == 0) ? 4'(imm) : 4'($urandom);
        in4  = (sel == 0) ? 4'(inp) : 4'($urandom);
        op8  = (sel == 1) ? 4'(op)  : 4'($urandom);
        imm8 = (sel == 1) ? 8'(imm) : 8'($urandom);
        in8  = (sel == 1) ? 8'(inp) : 8'($urandom);
        @(posedge clk);
        if (sel == 0) model_step(0, op, imm, inp);
        if (sel == 1) model_step(1, op, imm, inp);
        @(negedge clk);
        #1;
    endtask

    // Assert reset between edges. All outputs must clear at once, without a clock edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_pc4", pc4, 0); check("rst_a4", a4, 0); check("rst_b4", b4, 0);
        check("rst_o4", o4, 0);   check("rst_c4", c4, 0);
        check("rst_pc8", pc8, 0); check("rst_a8", a8, 0); check("rst_b8", b8, 0);
        check("rst_o8", o8, 0);   check("rst_c8", c8, 0);
        @(posedge clk);
        @(negedge clk);
        en4 = 1'b0;
        en8 = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    // Compare both cores against the model at every falling edge outside reset.
    always @(negedge clk) begin
        if (run && rst_n) begin
            check("pc4", pc4, m_pc[0]); check("a4", a4, m_a[0]); check("b4", b4, m_b[0]);
            check("out4", o4, m_o[0]);  check("c4", c4, m_c[0]);
            check("pc8", pc8, m_pc[1]); check("a8", a8, m_a[1]); check("b8", b8, m_b[1]);
            check("out8", o8, m_o[1]);  check("c8", c8, m_c[1]);
        end
    end

    initial begin
        rst_n = 1'b0;
        en4 = 1'b0; en8 = 1'b0;
        op4 = '0; op8 = '0; imm4 = '0; imm8 = '0; in4 = '0; in8 = '0;
        model_reset();
        #1;
        check("init_pc4", pc4, 0);
        check("init_a8", a8, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        run = 1'b1;

        // Reset and hold: bring the core to A=5, pc=7, then hold it with en low.
        exec(0, OP_MOVAI, 5, 0);
        for (int i = 0; i < 6; i++) exec(0, OP_NOP, 0, 0);
        check("pre_hold_a", a4, 5);
        check("pre_hold_pc", pc4, 7);
        for (int i = 0; i < 3; i++) exec(2, 0, 0, 0);
        check("hold_a", a4, 5);
        check("hold_pc", pc4, 7);
        // Reset during an enabled ADD aborts it.
        op4 = 4'(OP_ADDA); imm4 = 4'd1; en4 = 1'b1;
        do_reset();

        // ADD carry, 4-bit: 3 + 14 = 17, so A=1 and carry=1.
        exec(0, OP_MOVAI, 3, 0);
        exec(0, OP_ADDA, 14, 0);
        check("add_a", a4, 1);
        check("add_c", c4, 1);
        exec(0, OP_NOP, 0, 0);
        check("nop_c", c4, 0);
        check("nop_pc", pc4, 3);

        // JNC loop: pc alternates 1,2 until A wraps. JNC then falls through to pc 3.
        do_reset();
        exec(0, OP_MOVAI, 0, 0);
        for (int i = 0; i < 16; i++) begin
            exec(0, OP_ADDA, 1, 0);
            if (i < 15) begin
                check("loop_add_pc", pc4, 2);
                check("loop_add_c", c4, 0);
                exec(0, OP_JNC, 1, 0);
                check("loop_jnc_pc", pc4, 1);
            end
        end
        check("wrap_a", a4, 0);
        check("wrap_c", c4, 1);
        exec(0, OP_JNC, 1, 0);
        check("fall_pc", pc4, 3);
        check("fall_c", c4, 0);

        // Moves and I/O.
        do_reset();
        exec(0, OP_INB, 0, 9);
        exec(0, OP_MOVAB, 0, 0);
        exec(0, OP_ADDA, 2, 0);
        exec(0, OP_MOVBA, 0, 0);
        exec(0, OP_OUTB, 0, 0);
        check("io_out", o4, 11);
        check("io_a", a4, 11);
        check("io_b", b4, 11);
        exec(0, OP_OUTI, 6, 0);
        check("io_outi", o4, 6);

        // PC wrap across all NOP encodings, then jumps.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            case (i % 4)
                0: exec(0, 8, 0, 0);
                1: exec(0, 10, 0, 0);
                2: exec(0, 12, 0, 0);
                default: exec(0, 13, 0, 0);
            endcase
        end
        check("wrap_pc", pc4, 0);
        exec(0, OP_JMP, 13, 0);
        check("jmp_pc", pc4, 13);
        exec(1, OP_JMP, 8'hF3, 0);
        check("jmp8_pc", pc8, 3);

        // 8-bit arithmetic: 200 + 100 = 300, so A=44 and carry=1. Then 0 + 255 gives no carry.
        do_reset();
        exec(1, OP_MOVAI, 200, 0);
        exec(1, OP_ADDA, 100, 0);
        check("w8_a", a8, 44);
        check("w8_c", c8, 1);
        exec(1, OP_ADDB, 255, 0);
        check("w8_b", b8, 255);
        check("w8_c2", c8, 0);

        // Random instruction streams on both cores, with holds and occasional resets.
        for (int i = 0; i < 800; i++) begin
            int s;
            s = $urandom_range(0, 4);
            if ($urandom_range(0, 99) == 0) do_reset();
            else exec((s < 2) ? 0 : ((s < 4) ? 1 : 2),
                      $urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255));
        end

        run = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/td4_core_param.md
Name: td4_core_param

Overview:
- Parametrised single-cycle TD4-class accumulator CPU core: two general registers A/B, carry flag, output latch, program counter.
- Full 12-instruction TD4 set (ADD/MOV/IN/OUT/JMP/JNC) with proper carry semantics.
- Program memory is external: core drives `pc_out`, consumes `opcode`/`immediate` combinationally in the same cycle.
- Sits between the board-level program ROM/switch bank and the LED output port; successor of the fixed 4-bit core.

Parameters:
- DATA_W, 4, width of A, B, OUT, IN port and immediate field (≥2).
- PC_W, 4, program counter width; program space 2^PC_W words (1 ≤ PC_W ≤ DATA_W).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  execute enable; when low core holds all state (single-step/stall).
- opcode  input  4  instruction opcode at address pc_out.
- immediate  input  DATA_W  instruction immediate at address pc_out.
- in_port  input  DATA_W  external input port, sampled by IN instructions.
- pc_out  output  PC_W  current program counter.
- regA_o  output  DATA_W  register A.
- regB_o  output  DATA_W  register B.
- regOut  output  DATA_W  output latch.
- carry  output  1  carry flag.

Behaviour:
- Reset, asynchronous, active low: A=0, B=0, regOut=0, pc=0, carry=0. Reset mid-instruction aborts it; no partial update survives.
- Outputs are direct register values. No combinational path from inputs to outputs.
- Execution: one instruction per rising edge with en=1. Latency 1 cycle: the result is visible after the edge.
- With en=0, no register changes, including pc and carry.
- Opcode map. Im = immediate. Width-truncated results are mod 2^DATA_W.
  - 0000 ADD A,Im: A<=A+Im; carry<=carry-out bit DATA_W.
  - 0001 MOV A,B: A<=B.
  - 0010 IN A: A<=in_port.
  - 0011 MOV A,Im: A<=Im.
  - 0100 MOV B,A: B<=A.
  - 0101 ADD B,Im: B<=B+Im; carry<=carry-out.
  - 0110 IN B: B<=in_port.
  - 0111 MOV B,Im: B<=Im.
  - 1001 OUT B: regOut<=B.
  - 1011 OUT Im: regOut<=Im.
  - 1110 JNC Im: if carry==0, pc<=Im[PC_W-1:0], else pc<=pc+1.
  - 1111 JMP Im: pc<=Im[PC_W-1:0].
  - All other opcodes (1000, 1010, 1100, 1101): NOP; only pc advances.
- Carry rule: every executed non-ADD instruction, including NOP and JNC, clears carry. JNC tests the carry value held before its own edge.
- PC: pc<=pc+1 mod 2^PC_W unless a jump is taken. At all-ones, pc wraps to 0 with no flag.
- Immediate bits above PC_W are ignored for jumps.
- MOV A,B and MOV B,A read pre-edge values.
- in_port is sampled only on the executing edge of IN; no synchronisation inside the core.
- Unused register write enables are not asserted; registers are untouched by unrelated opcodes.

Test Plan:
- Reset/hold: assert rst_n=0 mid-run with A=5, pc=7. Required: all outputs 0 immediately, without waiting for a clock. With en=0 for 3 edges, all outputs stay constant.
- ADD carry (DATA_W=4): MOV A,3; ADD A,14 → A=1, carry=1. Next NOP → carry=0, pc advanced by 1.
- JNC loop: MOV A,0; ADD A,1; JNC 1 repeated. Required: pc cycles 1,2,1,2… until A wraps 15→0. At that point carry=1, JNC falls through to pc=3, and its execution clears carry.
- Moves/IO: in_port=9; IN B; MOV A,B; ADD A,2; MOV B,A; OUT B → regOut=11, regA_o=11, regB_o=11. Then OUT 6 → regOut=6.
- PC wrap and JMP: run 16 NOPs from pc=0 → pc returns to 0. JMP 13 → pc=13. With DATA_W=8, PC_W=4, JMP 0xF3 → pc=3.
- Parametric width: DATA_W=8. MOV A,200; ADD A,100 → A=44, carry=1. ADD B,255 with B=0 → B=255, carry=0.
